// File: rtl/inst_rom_pkg.sv
// Shared defines for the instruction memory responder: bus widths, memory sizing
// and FSM state encodings.
package inst_rom_pkg;

   localparam int InstAddrBus    = 32;
   localparam int InstBus        = 32;
   localparam logic [InstBus-1:0] ZeroWord = 32'h0;
   localparam int InstMemNum     = 1024;
   localparam int InstMemNumLog2 = 10;

   typedef enum logic {
      InstRomIdle = 1'b0,
      InstRomBusy = 1'b1
   } rom_state_e;

endpackage

// File: rtl/inst_rom_array.sv
// DEPTH x 32 synchronous storage: one write port, one registered read port.
// A same-edge write and read of one word returns the old contents.
module inst_rom_array
   import inst_rom_pkg::*;
#(
   parameter int DEPTH  = InstMemNum,
   parameter int ADDR_W = InstMemNumLog2
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  waddr_i,
   input  logic [InstBus-1:0] wdata_i,
   input  logic               re_i,
   input  logic [ADDR_W-1:0]  raddr_i,
   output logic [InstBus-1:0] rdata_o
);

   logic [InstBus-1:0] mem_q [DEPTH];
   logic [InstBus-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_rom.sv
// Instruction fetch responder with WAIT_CYCLES wait states and a preload port.
// Optional macro INST_ROM_ALIGN_CHECK_EN adds the misalign output.
module inst_rom
   import inst_rom_pkg::*;
#(
   parameter int DEPTH       = InstMemNum,
   parameter int ADDR_W      = InstMemNumLog2,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic [InstAddrBus-1:0] addr,
   input  logic                   ld_we,
   input  logic [ADDR_W-1:0]      ld_addr,
   input  logic [InstBus-1:0]     ld_data,
   output logic [InstBus-1:0]     inst,
   output logic                   inst_valid,
   output logic                   stall_req
`ifdef INST_ROM_ALIGN_CHECK_EN
   ,
   output logic                   misalign
`endif
);

   // cnt loads WAIT_CYCLES so the response lands WAIT_CYCLES+1 edges after accept
   localparam logic [3:0] CntReload = 4'(WAIT_CYCLES);
   localparam bit         HasWait   = (WAIT_CYCLES != 0);
`ifdef INST_ROM_ALIGN_CHECK_EN
   localparam bit         AlignChk  = 1'b1;
`else
   localparam bit         AlignChk  = 1'b0;
`endif

   rom_state_e             state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [InstAddrBus-1:0] addr_q, addr_d;
   logic                   ok_q, ok_d;
   logic                   vld_q;
   logic                   resp;
   logic                   in_range;
   logic                   aligned;
   logic [InstAddrBus-1:0] use_addr;
   logic [InstBus-1:0]     rdata;

   assign use_addr = (state_q == InstRomBusy) ? addr_q : addr;
   assign in_range = (use_addr[InstAddrBus-1:ADDR_W+2] == '0);
   assign aligned  = (use_addr[1:0] == 2'b00);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      ok_d    = ok_q;
      resp    = 1'b0;
      case (state_q)
         InstRomIdle: begin
            if (!ce) begin
               ok_d = 1'b0;
            end else if (HasWait) begin
               addr_d  = addr;
               cnt_d   = CntReload;
               state_d = InstRomBusy;
            end else begin
               resp = 1'b1;
            end
         end
         InstRomBusy: begin
            if (!ce) begin
               ok_d    = 1'b0;
               state_d = InstRomIdle;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               resp   = 1'b1;
               addr_d = addr;
               cnt_d  = CntReload;
            end
         end
         default: state_d = InstRomIdle;
      endcase
      // Out-of-range (and, when checked, misaligned) fetches present as NOP
      if (resp) begin
         ok_d = in_range && (aligned || !AlignChk);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= InstRomIdle;
         cnt_q   <= 4'd0;
         ok_q    <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
         vld_q   <= resp;
      end
      addr_q <= addr_d;
   end

`ifdef INST_ROM_ALIGN_CHECK_EN
   logic mis_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= resp && !aligned;
      end
   end

   assign misalign = mis_q;
`endif

   inst_rom_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .we_i    (ld_we),
      .waddr_i (ld_addr),
      .wdata_i (ld_data),
      .re_i    (resp),
      .raddr_i (use_addr[ADDR_W+1:2]),
      .rdata_o (rdata)
   );

   assign inst       = ok_q ? rdata : ZeroWord;
   assign inst_valid = vld_q;
   assign stall_req  = ce && ((state_q == InstRomIdle && HasWait) ||
                              (state_q == InstRomBusy && cnt_q != 4'd0));

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: one instance with no wait states, one with two.
module tb_inst_rom;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_we;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ce0, ce2;
   logic [31:0] addr0, addr2;
   logic [31:0] inst0, inst2;
   logic        vld0, vld2, stall0, stall2;
`ifdef INST_ROM_ALIGN_CHECK_EN
   logic        mis0, mis2;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   inst_rom #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .ce(ce0), .addr(addr0),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .inst(inst0), .inst_valid(vld0), .stall_req(stall0)
`ifdef INST_ROM_ALIGN_CHECK_EN
      , .misalign(mis0)
`endif
   );

   inst_rom #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .ce(ce2), .addr(addr2),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .inst(inst2), .inst_valid(vld2), .stall_req(stall2)
`ifdef INST_ROM_ALIGN_CHECK_EN
      , .misalign(mis2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [9:0] idx, input logic [31:0] data);
      ld_we   = 1'b1;
      ld_addr = idx;
      ld_data = data;
      tick();
      ld_we   = 1'b0;
   endtask

   // Accept a at the next edge E0 on dut2, disturb addr while busy, expect exp at E0+3.
   task automatic fetch2(input logic [31:0] a, input logic [31:0] exp, input string tag);
      ce2   = 1'b1;
      addr2 = a;
      #1 chk({tag, "_stall_idle"}, 32'(stall2), 32'd1);
      tick();
      chk({tag, "_stall_e0"}, 32'(stall2), 32'd1);
      chk({tag, "_vld_e0"}, 32'(vld2), 32'd0);
      addr2 = a ^ 32'h4;
      tick();
      chk({tag, "_stall_e1"}, 32'(stall2), 32'd1);
      tick();
      chk({tag, "_stall_e2"}, 32'(stall2), 32'd0);
      chk({tag, "_vld_e2"}, 32'(vld2), 32'd0);
      tick();
      chk({tag, "_inst_e3"}, inst2, exp);
      chk({tag, "_vld_e3"}, 32'(vld2), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] words [4];
      words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      rst = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      ce0 = 1'b0; ce2 = 1'b0; addr0 = '0; addr2 = '0;
      tick();
      for (int i = 0; i < 4; i++) ld(10'(i), words[i]);
      ld(10'd5, 32'h55555555);
      chk("rst_inst0", inst0, 32'h0);
      chk("rst_vld0", 32'(vld0), 32'd0);
      chk("rst_inst2", inst2, 32'h0);
      chk("rst_vld2", 32'(vld2), 32'd0);
      chk("rst_stall2", 32'(stall2), 32'd0);
      rst = 1'b1;

      // Zero-wait stream: one word per cycle, never stalls
      ce0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr0 = 32'(i * 4);
         #1 chk("stream_stall", 32'(stall0), 32'd0);
         tick();
         chk("stream_inst", inst0, words[i]);
         chk("stream_vld", 32'(vld0), 32'd1);
      end
      ce0 = 1'b0;
      tick();
      chk("idle_inst0", inst0, 32'h0);
      chk("idle_vld0", 32'(vld0), 32'd0);

      // Two wait states, then hold and abort
      fetch2(32'd8, 32'h33333333, "w2");
      tick();
      chk("hold_inst2", inst2, 32'h33333333);
      chk("hold_vld2", 32'(vld2), 32'd0);
      ce2 = 1'b0;
      #1 chk("abort_stall", 32'(stall2), 32'd0);
      tick();
      chk("abort_inst2", inst2, 32'h0);
      chk("abort_vld2", 32'(vld2), 32'd0);

      // Reset mid-busy drops the fetch, array survives
      fetch2(32'd8, 32'h33333333, "pre_rst");
      tick();
      rst = 1'b0;
      tick();
      chk("rst_busy_inst2", inst2, 32'h0);
      chk("rst_busy_vld2", 32'(vld2), 32'd0);
      chk("rst_busy_stall2", 32'(stall2), 32'd1);
      rst = 1'b1;
      ce2 = 1'b0;
      tick();
      chk("post_rst_vld2", 32'(vld2), 32'd0);
      fetch2(32'd8, 32'h33333333, "post_rst");
      ce2 = 1'b0;
      tick();

      // Same-edge write and read of word 5
      ce0 = 1'b1; addr0 = 32'd20;
      ld_we = 1'b1; ld_addr = 10'd5; ld_data = 32'hDEADBEEF;
      tick();
      ld_we = 1'b0;
      chk("rbw_old", inst0, 32'h55555555);
      chk("rbw_vld", 32'(vld0), 32'd1);
      tick();
      chk("rbw_new", inst0, 32'hDEADBEEF);

      addr0 = 32'h00010000;
      tick();
      chk("oor_inst", inst0, 32'h0);
      chk("oor_vld", 32'(vld0), 32'd1);
      addr0 = 32'd0;
      tick();
      chk("word0", inst0, 32'h11111111);

      addr0 = 32'd6;
      tick();
`ifdef INST_ROM_ALIGN_CHECK_EN
      chk("mis_inst", inst0, 32'h0);
      chk("mis_flag", 32'(mis0), 32'd1);
`else
      chk("unaligned_inst", inst0, 32'h22222222);
`endif
      chk("mis_vld", 32'(vld0), 32'd1);
      addr0 = 32'd4;
      tick();
      chk("aligned_inst", inst0, 32'h22222222);
`ifdef INST_ROM_ALIGN_CHECK_EN
      chk("mis_clear", 32'(mis0), 32'd0);
`endif
      ce0 = 1'b0;
      tick();
      chk("end_vld0", 32'(vld0), 32'd0);
      chk("end_inst0", inst0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
